// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: data type, sweep FSM
// states and port-count limits.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int MAX_RD = 4;
  localparam int MAX_WR = 2;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set on issue, cleared by
// writes or by the sweep. Bit 0 is hard-wired to zero.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                set_en,
  input  logic [AW-1:0]       set_idx,
  input  logic [NUM_REGS-1:0] clr_vec,
  input  logic                sweep_en,
  input  logic [AW-1:0]       sweep_idx,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next_s;

  // Next-state per bit: a set beats any clear; the sweep clears its index.
  always_comb begin
    busy_next_s = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_next_s[i] = (set_en && (set_idx == AW'(i)))     ? 1'b1 :
                       (sweep_en && (sweep_idx == AW'(i))) ? 1'b0 :
                       (busy_r[i] & ~clr_vec[i]);
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign busy_vec = busy_r;

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with x0 hard-wired to zero, a pending-producer
// scoreboard and a one-register-per-cycle sweep clear. Define RF_BYPASS_EN
// to forward same-cycle write data to the read ports.
module rf_mp
  import rf_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
  output data_t [NUM_RD-1:0]           rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  input  data_t [NUM_WR-1:0]           wr_data,
  input  logic                         iss_valid,
  input  logic [AW-1:0]                iss_rd,
  input  logic                         clr_req,
  output logic                         clr_busy
);

  if ((NUM_RD < 1) || (NUM_RD > MAX_RD) || (NUM_WR < 1) || (NUM_WR > MAX_WR)) begin : g_param_err
    $error("rf_mp: NUM_RD/NUM_WR outside supported range");
  end

`ifdef RF_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};

  data_t               regs_r [NUM_REGS];
  sweep_state_t        state_r;
  sweep_state_t        next_state_s;
  logic [AW-1:0]       sweep_idx_r;
  logic [AW-1:0]       sweep_idx_next_s;
  logic                sweeping_s;
  logic [NUM_WR-1:0]   wr_act_s;
  logic [NUM_REGS-1:0] clr_vec_s;
  logic [NUM_REGS-1:0] busy_vec_s;
  logic                set_en_s;

  assign sweeping_s = (state_r == SWEEP);
  assign set_en_s   = iss_valid && !sweeping_s && (iss_rd != IDX_ZERO);

  // Qualified write strobes and the scoreboard clear vector they produce.
  always_comb begin
    wr_act_s  = {NUM_WR{1'b0}};
    clr_vec_s = {NUM_REGS{1'b0}};
    for (int w = 0; w < NUM_WR; w++) begin
      wr_act_s[w] = we[w] && !sweeping_s && (wr_addr[w] != IDX_ZERO);
      clr_vec_s   = clr_vec_s |
                    (wr_act_s[w] ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << wr_addr[w])
                                 : {NUM_REGS{1'b0}});
    end
  end

  // Sweep FSM next-state and index.
  always_comb begin
    next_state_s     = state_r;
    sweep_idx_next_s = sweep_idx_r;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          next_state_s     = SWEEP;
          sweep_idx_next_s = IDX_ONE;
        end else begin
          next_state_s     = IDLE;
        end
      end
      SWEEP: begin
        sweep_idx_next_s = sweep_idx_r + IDX_ONE;
        if (sweep_idx_r == IDX_LAST) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = SWEEP;
        end
      end
      default: begin
        next_state_s     = IDLE;
        sweep_idx_next_s = IDX_ZERO;
      end
    endcase
  end

  // Sweep FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      sweep_idx_r <= IDX_ZERO;
    end else begin
      state_r     <= next_state_s;
      sweep_idx_r <= sweep_idx_next_s;
    end
  end

  // Register array: ascending port loop lets the higher port win a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_act_s[w]) begin
          regs_r[wr_addr[w]] <= wr_data[w];
        end
      end
      if (sweeping_s) begin
        regs_r[sweep_idx_r] <= {DATA_W{1'b0}};
      end
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_en    (set_en_s),
    .set_idx   (iss_rd),
    .clr_vec   (clr_vec_s),
    .sweep_en  (sweeping_s),
    .sweep_idx (sweep_idx_r),
    .busy_vec  (busy_vec_s)
  );

  // Combinational read ports with optional write forwarding.
  always_comb begin
    data_t val_s;
    rd_data = {NUM_RD{ {DATA_W{1'b0}} }};
    rd_busy = {NUM_RD{1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      val_s = (rd_addr[p] == IDX_ZERO) ? {DATA_W{1'b0}} : regs_r[rd_addr[p]];
      for (int w = 0; w < NUM_WR; w++) begin
        val_s = (BYPASS && wr_act_s[w] && (wr_addr[w] == rd_addr[p])) ? wr_data[w] : val_s;
      end
      rd_data[p] = val_s;
      rd_busy[p] = busy_vec_s[rd_addr[p]];
    end
  end

  assign clr_busy = sweeping_s;

endmodule

// File: doc/rf_mp.md
RF_MP -- requirements
Module: rf_mp

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers (power of two, 4..64).
REQ-002 SHALL have parameter NUM_RD, default 2, number of combinational read ports (1..4).
REQ-003 SHALL have parameter NUM_WR, default 1, number of write ports (1..2).
REQ-004 SHALL define AW = $clog2(NUM_REGS) as a localparam.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rd_addr, input, NUM_RD x AW, read address per read port.
REQ-008 SHALL have port rd_data, output, NUM_RD x data_t, read data per read port.
REQ-009 SHALL have port rd_busy, output, NUM_RD, scoreboard pending bit of the addressed register.
REQ-010 SHALL have port we, input, NUM_WR, write enable per write port.
REQ-011 SHALL have port wr_addr, input, NUM_WR x AW, write address per write port.
REQ-012 SHALL have port wr_data, input, NUM_WR x data_t, write data per write port.
REQ-013 SHALL have port iss_valid, input, 1, marks iss_rd as having a pending producer.
REQ-014 SHALL have port iss_rd, input, AW, destination register being reserved.
REQ-015 SHALL have port clr_req, input, 1, one-cycle pulse that starts a sweep clear.
REQ-016 SHALL have port clr_busy, output, 1, high while the sweep clear is in progress.

Function
REQ-017 Register 0 SHALL read as zero; writes and reservations to index 0 are ignored, and rd_busy for index 0 is always 0.
REQ-018 Reads SHALL be combinational, with zero-cycle latency from rd_addr to rd_data.
REQ-019 A write SHALL update the register at the next clk edge.
REQ-020 When two write ports target the same register in one cycle, the higher port index SHALL win.
REQ-021 A write SHALL clear the scoreboard bit of wr_addr.
REQ-022 iss_valid SHALL set the scoreboard bit of iss_rd.
REQ-023 When a set and a clear of the same scoreboard bit coincide, the set SHALL win.
REQ-024 rd_busy[p] SHALL equal the registered scoreboard bit of rd_addr[p], with no bypass of same-cycle sets or clears.
REQ-025 The sweep FSM SHALL have states IDLE and SWEEP.
REQ-026 In IDLE, clr_req SHALL transition the FSM to SWEEP and load the sweep index with 1.
REQ-027 In SWEEP, each cycle SHALL zero the register and scoreboard bit at the sweep index, then increment the index.
REQ-028 The FSM SHALL return to IDLE after index NUM_REGS-1 is cleared, so SWEEP lasts NUM_REGS-1 cycles.
REQ-029 clr_busy SHALL be 1 exactly while the FSM is in SWEEP.
REQ-030 While clr_busy is 1, we and iss_valid SHALL be ignored.
REQ-031 clr_req received while in SWEEP SHALL be ignored, with no restart.
REQ-032 Reads during SWEEP SHALL return the current contents: cleared entries read 0 and uncleared entries read their old values.

Reset
REQ-033 On reset_n low, all registers, all scoreboard bits and the sweep index SHALL clear to 0 asynchronously.
REQ-034 On reset_n low, the FSM SHALL go to IDLE and clr_busy SHALL be 0.
REQ-035 Reset asserted mid-sweep SHALL abort the sweep immediately.
REQ-036 rd_data SHALL read 0 and rd_busy SHALL read 0 for every address while reset_n is low and after release.

Configuration
REQ-037 With macro RF_BYPASS_EN defined, a read whose rd_addr matches an active write's wr_addr in the same cycle SHALL return that wr_data (winning port per REQ-020), except for index 0.
REQ-038 Without RF_BYPASS_EN, such a read SHALL return the old register value.

Structure
REQ-039 data_t SHALL come from the shared defines.
REQ-040 Package rf_pkg SHALL hold the sweep state enum (IDLE, SWEEP) and the constants MAX_RD=4 and MAX_WR=2.
REQ-041 rf_mp SHALL check its parameters against MAX_RD and MAX_WR with an elaboration-time assertion.
REQ-042 The scoreboard SHALL be a separate sub-module, rf_scoreboard, with set, clear-vector and sweep-clear inputs.

Verification
REQ-043 Write x5=0xDEADBEEF, then read x5 on both read ports the next cycle -> rd_data=0xDEADBEEF on both.
REQ-044 Write x0=0x1234, then read x0 -> rd_data=0; iss_valid with iss_rd=0, then read x0 -> rd_busy=0.
REQ-045 NUM_WR=2, both ports write x7 (port0=0x11, port1=0x22) -> x7 reads 0x22.
REQ-046 Read x3 while writing x3=0xAA in the same cycle -> rd_data=0xAA with RF_BYPASS_EN, old value without it.
REQ-047 iss_valid on x9 -> rd_busy=1 next cycle; iss_valid on x9 and write x9 in the same cycle -> rd_busy stays 1; write x9 alone -> rd_busy=0.
REQ-048 Fill x1..x31 with nonzero values, pulse clr_req -> clr_busy high for 31 cycles with writes ignored; all registers read 0 afterwards; reset_n low at sweep cycle 10 -> clr_busy=0 and all registers 0.
